// File: rtl/food_placer.sv
// Food placement engine: turns free-running LFSR coordinates into a legal,
// unoccupied food cell through rejection sampling and an occupancy query.
module food_placer #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rand_x,
    input  logic [9:0] rand_y,
    input  logic       place_req,
    input  logic       clear,
    output logic       occ_req,
    output logic [9:0] occ_x,
    output logic [9:0] occ_y,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [9:0] food_x,
    output logic [9:0] food_y,
    output logic       food_valid,
    output logic       place_done,
    output logic       place_fail,
    output logic       busy
);

    localparam int         XBITS    = $clog2(GRID_W);
    localparam int         YBITS    = $clog2(GRID_H);
    localparam logic [10:0] XMASK_W = (11'd1 << XBITS) - 11'd1;
    localparam logic [10:0] YMASK_W = (11'd1 << YBITS) - 11'd1;
    localparam logic [9:0] XMASK    = XMASK_W[9:0];
    localparam logic [9:0] YMASK    = YMASK_W[9:0];
    localparam logic [10:0] GRID_W_L = 11'(GRID_W);
    localparam logic [10:0] GRID_H_L = 11'(GRID_H);
    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] tries_r;
    logic [9:0] cand_x_r;
    logic [9:0] cand_y_r;
    logic [9:0] food_x_r;
    logic [9:0] food_y_r;
    logic       food_valid_r;
    logic       place_done_r;
    logic       place_fail_r;
    logic       start_s;
    logic       accept_s;
    logic       reject_s;
    logic       last_try_s;
    logic       out_of_range_s;

    assign last_try_s     = (tries_r == LAST_TRY);
    assign out_of_range_s = ({1'b0, cand_x_r} >= GRID_W_L) || ({1'b0, cand_y_r} >= GRID_H_L);

    // Next-state decode; clear overrides every transition including same-cycle acks.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        if (clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (place_req) begin
                        state_nxt_s = ST_SAMPLE;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    state_nxt_s = ST_CHECK;
                end
                ST_CHECK: begin
                    if (out_of_range_s) begin
                        reject_s    = 1'b1;
                        state_nxt_s = last_try_s ? ST_FAIL : ST_SAMPLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (occ_ack && occ_hit) begin
                        reject_s    = 1'b1;
                        state_nxt_s = last_try_s ? ST_FAIL : ST_SAMPLE;
                    end else if (occ_ack) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_FAIL: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Candidate capture, retry counter and published food cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tries_r      <= 8'd0;
            cand_x_r     <= 10'd0;
            cand_y_r     <= 10'd0;
            food_x_r     <= 10'd0;
            food_y_r     <= 10'd0;
            food_valid_r <= 1'b0;
            place_done_r <= 1'b0;
            place_fail_r <= 1'b0;
        end else begin
            place_done_r <= 1'b0;
            place_fail_r <= 1'b0;
            if (clear) begin
                tries_r      <= 8'd0;
                food_valid_r <= 1'b0;
            end else begin
                if (start_s) begin
                    tries_r      <= 8'd0;
                    food_valid_r <= 1'b0;
                end
                if (state_r == ST_SAMPLE) begin
                    cand_x_r <= rand_x & XMASK;
                    cand_y_r <= rand_y & YMASK;
                end
                if (reject_s && !last_try_s) begin
                    tries_r <= tries_r + 8'd1;
                end
                // The final rejection raises place_fail for the single FAIL cycle.
                if (reject_s && last_try_s) begin
                    place_fail_r <= 1'b1;
                end
                if (accept_s) begin
                    food_x_r     <= cand_x_r;
                    food_y_r     <= cand_y_r;
                    food_valid_r <= 1'b1;
                    place_done_r <= 1'b1;
                end
            end
        end
    end

    assign occ_req    = (state_r == ST_WAIT);
    assign occ_x      = cand_x_r;
    assign occ_y      = cand_y_r;
    assign busy       = (state_r != ST_IDLE);
    assign food_x     = food_x_r;
    assign food_y     = food_y_r;
    assign food_valid = food_valid_r;
    assign place_done = place_done_r;
    assign place_fail = place_fail_r;

endmodule

// File: tb/tb_food_placer.sv
// Self-checking bench for food_placer: directed scenarios plus randomized
// placements checked against a transaction-level timeline model.
module tb_food_placer;

    localparam int GW    = 40;
    localparam int GH    = 30;
    localparam int MT    = 16;
    localparam int XMASK = (1 << $clog2(GW)) - 1;
    localparam int YMASK = (1 << $clog2(GH)) - 1;

    logic       clk;
    logic       rst;
    logic [9:0] rand_x;
    logic [9:0] rand_y;
    logic       place_req;
    logic       clear;
    logic       occ_req;
    logic [9:0] occ_x;
    logic [9:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;
    logic [9:0] food_x;
    logic [9:0] food_y;
    logic       food_valid;
    logic       place_done;
    logic       place_fail;
    logic       busy;

    int checks;
    int failures;
    int exp_fx;
    int exp_fy;
    bit spurious;
    int fq_x[$];
    int fq_y[$];
    int fq_h[$];
    int fq_d[$];

    food_placer #(.GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .rand_x(rand_x), .rand_y(rand_y),
        .place_req(place_req), .clear(clear), .occ_req(occ_req),
        .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .place_done(place_done), .place_fail(place_fail), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic noise();
        rand_x = 10'($urandom_range(0, 1023));
        rand_y = 10'($urandom_range(0, 1023));
    endtask

    task automatic chk_food(input string tag, input int valid, input int done);
        chk({tag, "_fx"}, int'(food_x), exp_fx);
        chk({tag, "_fy"}, int'(food_y), exp_fy);
        chk({tag, "_valid"}, int'(food_valid), valid);
        chk({tag, "_done"}, int'(place_done), done);
    endtask

    // One placement: each candidate takes SAMPLE+CHECK, in-range ones add
    // WAIT cycles until the ack; success or exhaustion ends the transaction.
    task automatic do_place(output int queries, output bit done_seen);
        int rx, ry, cx, cy, d, h;
        queries   = 0;
        done_seen = 1'b0;
        chk("idle_busy", int'(busy), 0);
        noise();
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        for (int k = 0; k < MT; k++) begin
            chk("smp_busy", int'(busy), 1);
            chk("smp_occreq", int'(occ_req), 0);
            if (fq_x.size() > 0) begin
                rx = fq_x.pop_front();
                ry = fq_y.pop_front();
            end else if ($urandom_range(0, 1) == 0) begin
                rx = $urandom_range(0, 1023);
                ry = $urandom_range(0, 1023);
            end else begin
                rx = $urandom_range(0, GW - 1);
                ry = $urandom_range(0, GH - 1);
            end
            rand_x    = 10'(rx);
            rand_y    = 10'(ry);
            cx        = rx & XMASK;
            cy        = ry & YMASK;
            occ_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            occ_hit   = 1'b0;
            place_req = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk("chk_occreq", int'(occ_req), 0);
            chk("chk_done", int'(place_done), 0);
            noise();
            tick();
            occ_ack   = 1'b0;
            place_req = 1'b0;
            if (cx >= GW || cy >= GH) continue;
            queries++;
            if (fq_h.size() > 0) begin
                h = fq_h.pop_front();
                d = fq_d.pop_front();
            end else begin
                h = ($urandom_range(0, 2) == 0) ? 1 : 0;
                d = $urandom_range(0, 3);
            end
            for (int i = 0; i <= d; i++) begin
                chk("wait_occreq", int'(occ_req), 1);
                chk("wait_occx", int'(occ_x), cx);
                chk("wait_occy", int'(occ_y), cy);
                chk("wait_busy", int'(busy), 1);
                noise();
                place_req = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
                occ_ack   = (i == d);
                occ_hit   = (i == d) ? 1'(h) : 1'($urandom_range(0, 1));
                tick();
            end
            occ_ack   = 1'b0;
            occ_hit   = 1'b0;
            place_req = 1'b0;
            if (h == 0) begin
                exp_fx = cx;
                exp_fy = cy;
                chk_food("acc", 1, 1);
                chk("acc_busy", int'(busy), 0);
                chk("acc_fail", int'(place_fail), 0);
                tick();
                chk("acc_done_pulse", int'(place_done), 0);
                done_seen = 1'b1;
                return;
            end
        end
        chk("fail_pulse", int'(place_fail), 1);
        chk("fail_busy", int'(busy), 1);
        chk_food("fail", 0, 0);
        tick();
        chk("fail_pulse_end", int'(place_fail), 0);
        chk("fail_idle", int'(busy), 0);
        chk_food("after_fail", 0, 0);
    endtask

    initial begin
        int  q;
        bit  ok;
        int  n_done;
        checks    = 0;
        failures  = 0;
        exp_fx    = 0;
        exp_fy    = 0;
        spurious  = 1'b0;
        rst       = 1'b1;
        place_req = 1'b0;
        clear     = 1'b0;
        occ_ack   = 1'b0;
        occ_hit   = 1'b0;
        rand_x    = 10'd0;
        rand_y    = 10'd0;
        @(negedge clk);
        @(negedge clk);
        chk_food("rst", 0, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_occreq", int'(occ_req), 0);
        chk("rst_fail", int'(place_fail), 0);
        rst = 1'b0;
        tick();

        // Happy path
        fq_x = '{12}; fq_y = '{7}; fq_h = '{0}; fq_d = '{0};
        do_place(q, ok);
        chk("happy_queries", q, 1);
        chk("happy_done", int'(ok), 1);
        chk("happy_fx", exp_fx, 12);
        chk("happy_fy", exp_fy, 7);

        // Range rejection: only the third sample is queried
        fq_x = '{45, 300, 5}; fq_y = '{3, 100, 70}; fq_h = '{0}; fq_d = '{0};
        do_place(q, ok);
        chk("range_queries", q, 1);
        chk("range_fx", exp_fx, 5);
        chk("range_fy", exp_fy, 6);

        // Occupied then a slow ack
        fq_x = '{3, 9}; fq_y = '{3, 2}; fq_h = '{1, 0}; fq_d = '{0, 4};
        do_place(q, ok);
        chk("occ_queries", q, 2);
        chk("occ_fx", exp_fx, 9);
        chk("occ_fy", exp_fy, 2);

        // Exhaustion with ignored place_req and stray acks while busy
        fq_x.delete(); fq_y.delete(); fq_h.delete(); fq_d.delete();
        for (int i = 0; i < MT; i++) begin
            fq_x.push_back($urandom_range(0, GW - 1));
            fq_y.push_back($urandom_range(0, GH - 1));
            fq_h.push_back(1);
            fq_d.push_back($urandom_range(0, 2));
        end
        spurious = 1'b1;
        do_place(q, ok);
        spurious = 1'b0;
        chk("exh_queries", q, MT);
        chk("exh_done", int'(ok), 0);

        // Abort coincident with a clean ack, then a late ack
        noise();
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        rand_x = 10'd20;
        rand_y = 10'd10;
        tick();
        noise();
        tick();
        chk("abort_occreq", int'(occ_req), 1);
        chk("abort_occx", int'(occ_x), 20);
        clear   = 1'b1;
        occ_ack = 1'b1;
        occ_hit = 1'b0;
        tick();
        clear = 1'b0;
        chk_food("abort", 0, 0);
        chk("abort_busy", int'(busy), 0);
        tick();
        occ_ack = 1'b0;
        chk_food("late_ack", 0, 0);
        chk("late_ack_busy", int'(busy), 0);
        clear     = 1'b1;
        place_req = 1'b1;
        tick();
        clear     = 1'b0;
        place_req = 1'b0;
        chk("clear_req_busy", int'(busy), 0);

        // Randomized placements
        spurious = 1'b1;
        n_done   = 0;
        for (int t = 0; t < 40; t++) begin
            do_place(q, ok);
            if (ok) n_done++;
            repeat ($urandom_range(0, 2)) begin
                noise();
                tick();
            end
        end
        spurious = 1'b0;
        chk("rand_some_done", int'(n_done > 0), 1);

        // Asynchronous reset mid-query
        fq_x = '{8}; fq_y = '{8};
        noise();
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        rand_x = 10'd8;
        rand_y = 10'd8;
        tick();
        tick();
        fq_x.delete(); fq_y.delete();
        chk("prerst_occreq", int'(occ_req), 1);
        rst = 1'b1;
        #1;
        exp_fx = 0;
        exp_fy = 0;
        chk("arst_occreq", int'(occ_req), 0);
        chk("arst_busy", int'(busy), 0);
        chk_food("arst", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
